alu_shift_seq: RTL and testbench
================================

// Module: alu_shift_seq
// PURPOSE
//   Multi-cycle, parametrised shift unit for the ALU datapath. It supports
//   logical left (SLL), logical right (SRL), arithmetic right (SRA) and rotate
//   right (ROR) shifts. It shifts at most STEP bit positions per clock, with a
//   start/busy/done handshake. Results and z/n/v flags are registered and held
//   for the ALU writeback stage. It replaces the single-cycle shifter path for
//   wide datapaths, where a full barrel shifter is too costly.
// PARAMETERS
//   WIDTH    16                 data width; power of 2, >= 4
//   STEP     1                  max bit positions shifted per cycle; power of 2, <= WIDTH
//   SHAMT_W  $clog2(WIDTH)      shift-amount width (derived, not overridden)
// PORTS
//   clk      in   1        single clock, rising edge
//   rst_n    in   1        asynchronous, active-low reset
//   start    in   1        request; accepted on a rising edge when busy==0
//   mode     in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled with start
//   data_in  in   WIDTH    operand; sampled with start
//   shamt    in   SHAMT_W  shift amount 0..WIDTH-1; sampled with start
//   busy     out  1        high while in the SHIFT state
//   done     out  1        one-cycle pulse: result and flags are newly valid
//   result   out  WIDTH    registered result; held until the next completion
//   z        out  1        result == 0
//   n        out  1        result[WIDTH-1]
//   v        out  1        SLL only: a 1 bit was shifted out of the MSB; else 0
// BEHAVIOUR
//   Reset (rst_n low, asynchronous): state IDLE; busy, done, result, z, n, v
//     all 0; internal working register and count cleared. Reset mid-SHIFT
//     aborts the operation and produces no done.
//   FSM IDLE -> SHIFT -> DONE -> IDLE.
//   - Accept: at edge k with start=1 and busy=0, in state IDLE or DONE.
//     - Load work=data_in, cnt=shamt, latch mode, clear the sticky overflow.
//     - Next state is SHIFT, or DONE when shamt==0.
//   - SHIFT: each edge shifts work by s=min(STEP,cnt) and sets cnt=cnt-s.
//     - SLL fills 0 at the LSB.
//     - SRL fills 0 at the MSB.
//     - SRA fills copies of the latched operand's MSB.
//     - ROR wraps the low bits to the top.
//     - SLL only: the sticky v_acc ORs in every bit shifted out of the MSB.
//     - When cnt becomes 0, go to DONE.
//   - DONE entry (same edge): result<=work, z<=(work==0), n<=work[WIDTH-1],
//     v<=v_acc for SLL (0 for other modes).
//   - done is high for exactly one cycle. The next state is IDLE, or the
//     accept path when start is asserted.
//   Latency: done is high in the cycle after edge k+ceil(shamt/STEP).
//     shamt==0 gives done in the cycle after edge k.
//   start while busy==1 is ignored. It is not queued, and inputs are not
//     re-sampled.
//   Back-to-back: start during the done cycle is accepted. The previous
//     result and flags stay on the outputs until the new done.
//   result, z, n and v change only on DONE entry or reset, never during SHIFT.
//   shamt wraps naturally in SHAMT_W bits; values >= WIDTH cannot be
//     expressed.
// TESTING
//   1 W16,STEP1: SRA 0xAA00, shamt 4
//     -> result 0xFAA0, n=1 z=0 v=0; done in the cycle after edge k+4;
//        busy high for 4 cycles.
//   2 SRA 0x00FF, shamt 8 -> result 0x0000, z=1 n=0 v=0.
//     SRA 0xFFFF, shamt 1 -> result 0xFFFF, n=1.
//   3 SLL 0x8001, shamt 1 -> 0x0002, v=1.
//     SLL 0x4001, shamt 1 -> 0x8002, v=0 n=1.
//     SRL 0x8000, shamt 15 -> 0x0001.
//   4 W16,STEP4: ROR 0x0001, shamt 15 -> 0x0002, done in the cycle after
//     edge k+4. ROR 0x1234, shamt 0 -> 0x1234, done in the cycle after edge k.
//   5 start pulsed mid-SHIFT with different operands -> ignored, original
//     result delivered. start in the done cycle -> accepted, busy the next
//     cycle, prior result held.
//   6 rst_n low for 1 ns during SHIFT -> busy/done/result/flags 0
//     immediately, no done pulse; the next start completes normally.

Source files
------------

// File: rtl/alu_shift_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_shift_seq
// Description : Multi-cycle shift unit for the ALU datapath. Performs SLL,
//               SRL, SRA and ROR, moving at most STEP bit positions per clock.
//               The operation is started with a start/busy/done handshake.
//               The result and z/n/v flags are registered and held until the
//               next completion.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1        clock, rising edge
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request; accepted on a rising edge while busy==0
//   mode     in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (sampled with start)
//   data_in  in   WIDTH    operand (sampled with start)
//   shamt    in   SHAMT_W  shift amount 0..WIDTH-1 (sampled with start)
//   busy     out  1        high while shifting
//   done     out  1        one-cycle pulse: result/flags newly valid
//   result   out  WIDTH    registered result
//   z        out  1        result == 0
//   n        out  1        result MSB
//   v        out  1        SLL only: a 1 was shifted out of the MSB
// ============================================================================
module alu_shift_seq #(
    parameter  int WIDTH   = 16,
    parameter  int STEP    = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               z,
    output logic               n,
    output logic               v
);

    // One extra bit so both STEP and WIDTH are representable as shift amounts.
    localparam int SW = SHAMT_W + 1;

    localparam logic [SW-1:0]    c_STEP     = SW'(STEP);
    localparam logic [SW-1:0]    c_WIDTH_SW = SW'(WIDTH);
    localparam logic [WIDTH-1:0] c_ONES     = {WIDTH{1'b1}};

    localparam logic [1:0] c_MODE_SLL = 2'b00;
    localparam logic [1:0] c_MODE_SRL = 2'b01;
    localparam logic [1:0] c_MODE_SRA = 2'b10;
    localparam logic [1:0] c_MODE_ROR = 2'b11;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state_q,  w_state_d;
    logic [WIDTH-1:0]   r_work_q,   w_work_d;
    logic [SHAMT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [1:0]         r_mode_q,   w_mode_d;
    logic               r_sign_q,   w_sign_d;
    logic               r_v_acc_q,  w_v_acc_d;
    logic [WIDTH-1:0]   r_result_q, w_result_d;
    logic               r_z_q,      w_z_d;
    logic               r_n_q,      w_n_d;
    logic               r_v_q,      w_v_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_accept;
    logic [SW-1:0]      w_cnt_ext;
    logic [SW-1:0]      w_s;
    logic [WIDTH-1:0]   w_hi_mask;
    logic [WIDTH-1:0]   w_srl;
    logic [WIDTH-1:0]   w_rot_hi;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_out_bits;

    // A request is taken whenever the unit is not mid-shift (IDLE or DONE).
    assign w_accept  = start && (r_state_q != c_ST_SHIFT);
    assign w_cnt_ext = {1'b0, r_cnt_q};

    always_comb begin
        w_s       = (w_cnt_ext < c_STEP) ? w_cnt_ext : c_STEP;
        // Top w_s bits set: the positions vacated by a right shift and the
        // positions leaving the word on a left shift.
        w_hi_mask = ~(c_ONES >> w_s);
        w_srl     = r_work_q >> w_s;
        // A shift by WIDTH yields zero, so w_s==0 leaves ROR an identity.
        w_rot_hi  = r_work_q << (c_WIDTH_SW - w_s);
        w_out_bits = |(r_work_q & w_hi_mask);
        w_shifted = r_work_q;
        case (r_mode_q)
            c_MODE_SLL: w_shifted = r_work_q << w_s;
            c_MODE_SRL: w_shifted = w_srl;
            // Fill from the sign latched at accept time.
            c_MODE_SRA: w_shifted = w_srl | (r_sign_q ? w_hi_mask : '0);
            c_MODE_ROR: w_shifted = w_srl | w_rot_hi;
            default:    w_shifted = r_work_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE, c_ST_DONE: begin
                if (w_accept) begin
                    w_state_d = (shamt == '0) ? c_ST_DONE : c_ST_SHIFT;
                end else begin
                    w_state_d = c_ST_IDLE;
                end
            end
            c_ST_SHIFT: begin
                // The remaining count fits in this step: finish now.
                if (w_cnt_ext <= c_STEP) begin
                    w_state_d = c_ST_DONE;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy   = (r_state_q == c_ST_SHIFT);
        done   = (r_state_q == c_ST_DONE);
        result = r_result_q;
        z      = r_z_q;
        n      = r_n_q;
        v      = r_v_q;
    end

    // ------------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_work_d   = r_work_q;
        w_cnt_d    = r_cnt_q;
        w_mode_d   = r_mode_q;
        w_sign_d   = r_sign_q;
        w_v_acc_d  = r_v_acc_q;
        w_result_d = r_result_q;
        w_z_d      = r_z_q;
        w_n_d      = r_n_q;
        w_v_d      = r_v_q;

        if (w_accept) begin
            w_work_d  = data_in;
            w_cnt_d   = shamt;
            w_mode_d  = mode;
            w_sign_d  = data_in[WIDTH-1];
            w_v_acc_d = 1'b0;
        end else if (r_state_q == c_ST_SHIFT) begin
            w_work_d  = w_shifted;
            // w_s never exceeds the count, so the narrowing is lossless.
            w_cnt_d   = r_cnt_q - w_s[SHAMT_W-1:0];
            w_v_acc_d = r_v_acc_q | ((r_mode_q == c_MODE_SLL) && w_out_bits);
        end

        // Every transition into DONE (including a zero-shift accept from DONE)
        // publishes the work value computed on that same edge.
        if (w_state_d == c_ST_DONE) begin
            w_result_d = w_work_d;
            w_z_d      = (w_work_d == '0);
            w_n_d      = w_work_d[WIDTH-1];
            w_v_d      = (w_mode_d == c_MODE_SLL) && w_v_acc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work_q   <= '0;
            r_cnt_q    <= '0;
            r_mode_q   <= '0;
            r_sign_q   <= 1'b0;
            r_v_acc_q  <= 1'b0;
            r_result_q <= '0;
            r_z_q      <= 1'b0;
            r_n_q      <= 1'b0;
            r_v_q      <= 1'b0;
        end else begin
            r_work_q   <= w_work_d;
            r_cnt_q    <= w_cnt_d;
            r_mode_q   <= w_mode_d;
            r_sign_q   <= w_sign_d;
            r_v_acc_q  <= w_v_acc_d;
            r_result_q <= w_result_d;
            r_z_q      <= w_z_d;
            r_n_q      <= w_n_d;
            r_v_q      <= w_v_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_shift_seq
// Description : Directed self-checking bench for alu_shift_seq. Two instances
//               (STEP=1 and STEP=4) share operand inputs; sel4 picks which
//               one is driven and observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_shift_seq;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start1  = 1'b0;
    logic        start4  = 1'b0;
    logic [1:0]  mode    = 2'b00;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  shamt   = 4'h0;
    logic        sel4    = 1'b0;

    logic        busy1, done1, z1, n1, v1;
    logic [15:0] result1;
    logic        busy4, done4, z4, n4, v4;
    logic [15:0] result4;

    logic        busy_m, done_m, z_m, n_m, v_m;
    logic [15:0] result_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int bcnt;
    int dcnt;

    always #5 clk = ~clk;

    alu_shift_seq #(.WIDTH(16), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode),
        .data_in(data_in), .shamt(shamt), .busy(busy1), .done(done1),
        .result(result1), .z(z1), .n(n1), .v(v1)
    );

    alu_shift_seq #(.WIDTH(16), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode),
        .data_in(data_in), .shamt(shamt), .busy(busy4), .done(done4),
        .result(result4), .z(z4), .n(n4), .v(v4)
    );

    assign busy_m   = sel4 ? busy4   : busy1;
    assign done_m   = sel4 ? done4   : done1;
    assign result_m = sel4 ? result4 : result1;
    assign z_m      = sel4 ? z4      : z1;
    assign n_m      = sel4 ? n4      : n1;
    assign v_m      = sel4 ? v4      : v1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current negedge; returns at the negedge after
    // the accepting edge.
    task automatic launch(input logic use4, input logic [1:0] m,
                          input logic [15:0] d, input logic [3:0] s);
        sel4 = use4; mode = m; data_in = d; shamt = s;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        @(negedge clk);
    endtask

    // Called at the negedge after edge k+j; counts further edges until done.
    task automatic wait_done(output int c, output int b);
        c = 0; b = 0;
        while (done_m !== 1'b1 && c < 100) begin
            if (busy_m === 1'b1) b++;
            c++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic use4, input logic [1:0] m,
                          input logic [15:0] d, input logic [3:0] s,
                          input logic [15:0] er, input logic ez, input logic en,
                          input logic ev, input int elat);
        int c, b;
        @(negedge clk);
        launch(use4, m, d, s);
        wait_done(c, b);
        check({tag, ".lat"},  c, elat);
        check({tag, ".busy"}, b, elat);
        check({tag, ".res"},  result_m, er);
        check({tag, ".z"},    z_m, ez);
        check({tag, ".n"},    n_m, en);
        check({tag, ".v"},    v_m, ev);
        @(negedge clk);
        check({tag, ".pulse"}, done_m, 1'b0);
        check({tag, ".hold"},  result_m, er);
    endtask

    initial begin
        // Reset state on both instances
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel4 = (i == 1);
            #1;
            check("rst.busy", busy_m, 1'b0);
            check("rst.done", done_m, 1'b0);
            check("rst.res",  result_m, 16'h0000);
            check("rst.z",    z_m, 1'b0);
            check("rst.n",    n_m, 1'b0);
            check("rst.v",    v_m, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // STEP=1
        run_op("sra4",   1'b0, SRA, 16'hAA00, 4'd4,  16'hFAA0, 1'b0, 1'b1, 1'b0, 4);
        run_op("sra8",   1'b0, SRA, 16'h00FF, 4'd8,  16'h0000, 1'b1, 1'b0, 1'b0, 8);
        run_op("sra1",   1'b0, SRA, 16'hFFFF, 4'd1,  16'hFFFF, 1'b0, 1'b1, 1'b0, 1);
        run_op("sll_v1", 1'b0, SLL, 16'h8001, 4'd1,  16'h0002, 1'b0, 1'b0, 1'b1, 1);
        run_op("sll_v0", 1'b0, SLL, 16'h4001, 4'd1,  16'h8002, 1'b0, 1'b1, 1'b0, 1);
        run_op("srl15",  1'b0, SRL, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0, 1'b0, 15);

        // STEP=4
        run_op("ror15",  1'b1, ROR, 16'h0001, 4'd15, 16'h0002, 1'b0, 1'b0, 1'b0, 4);
        run_op("ror0",   1'b1, ROR, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0, 1'b0, 0);
        run_op("sll6s4", 1'b1, SLL, 16'h0F00, 4'd6,  16'hC000, 1'b0, 1'b1, 1'b1, 2);
        run_op("sra7s4", 1'b1, SRA, 16'h8000, 4'd7,  16'hFF00, 1'b0, 1'b1, 1'b0, 2);

        // start mid-SHIFT is ignored
        @(negedge clk);
        launch(1'b0, SRL, 16'hF000, 4'd4);
        check("mid.busy", busy_m, 1'b1);
        mode = SLL; data_in = 16'h0001; shamt = 4'd1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk);
        wait_done(cyc, bcnt);
        check("mid.lat", cyc, 3);
        check("mid.res", result_m, 16'h0F00);
        check("mid.v",   v_m, 1'b0);

        // start in the done cycle is accepted; prior result held meanwhile
        launch(1'b0, ROR, 16'h0003, 4'd2);
        check("b2b.busy", busy_m, 1'b1);
        check("b2b.done", done_m, 1'b0);
        check("b2b.hold", result_m, 16'h0F00);
        wait_done(cyc, bcnt);
        check("b2b.lat", cyc, 2);
        check("b2b.res", result_m, 16'hC000);
        check("b2b.n",   n_m, 1'b1);

        // Asynchronous reset mid-SHIFT
        @(negedge clk);
        launch(1'b0, SLL, 16'h00FF, 4'd8);
        check("ar.busy0", busy_m, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar.busy", busy_m, 1'b0);
        check("ar.done", done_m, 1'b0);
        check("ar.res",  result_m, 16'h0000);
        check("ar.z",    z_m, 1'b0);
        check("ar.n",    n_m, 1'b0);
        check("ar.v",    v_m, 1'b0);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_m === 1'b1 || busy_m === 1'b1) dcnt++;
        end
        check("ar.nodone", dcnt, 0);
        run_op("ar.next", 1'b0, SLL, 16'h00FF, 4'd8, 16'hFF00, 1'b0, 1'b1, 1'b0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
